// File: rtl/multiway_trafficlight_if.sv
// Sensor/lamp bundle for the multi-approach traffic controller.
// The controller binds to the slave side; the sensor/stimulus side binds to master.
interface multiway_trafficlight_if #(
    parameter int NUM_DIR = 4
);
    localparam int DIR_W = $clog2(NUM_DIR);

    logic [NUM_DIR-1:0]   demand;
    logic [NUM_DIR-1:0]   emgcy;
    logic [3*NUM_DIR-1:0] light;
    logic [DIR_W-1:0]     active_dir;
    logic                 emgcy_active;

    modport master (
        output demand,
        output emgcy,
        input  light,
        input  active_dir,
        input  emgcy_active
    );

    modport slave (
        input  demand,
        input  emgcy,
        output light,
        output active_dir,
        output emgcy_active
    );
endinterface

// File: rtl/multiway_trafficlight.sv
// N-approach traffic controller: home direction rests in green, side directions are
// served round-robin on latched demand, and per-direction emergencies preempt the cycle.
module multiway_trafficlight #(
    parameter int NUM_DIR      = 4,
    parameter int GREEN_MIN    = 4,
    parameter int GREEN_MAX    = 8,
    parameter int YELLOW_CYC   = 2,
    parameter int ALLRED_CYC   = 1,
    parameter int PREGREEN_CYC = 1,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    multiway_trafficlight_if.slave  bus
);
    localparam int DIR_W = $clog2(NUM_DIR);

    localparam logic [CNT_W-1:0] GMIN_LAST     = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST     = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST   = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST   = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] PREGREEN_LAST = CNT_W'(PREGREEN_CYC - 1);

    localparam logic [2:0] LAMP_OFF      = 3'd0;
    localparam logic [2:0] LAMP_RED      = 3'd1;
    localparam logic [2:0] LAMP_YELLOW   = 3'd2;
    localparam logic [2:0] LAMP_GREEN    = 3'd3;
    localparam logic [2:0] LAMP_PREGREEN = 3'd4;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_ALLRED,
        ST_PREGREEN,
        ST_GREEN,
        ST_YELLOW
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   elapsed_reg, elapsed_next, elapsed_inc;
    logic [DIR_W-1:0]   active_dir_reg, active_dir_next;
    logic [DIR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [DIR_W-1:0]   target_reg, target_next;
    logic               emgcy_active_reg, emgcy_active_next;
    logic [NUM_DIR-1:0] req_reg, req_next;

    logic [DIR_W-1:0]   scan_dir, cap_dir, next_dir;
    logic               scan_found, capture, side_pending, serve_entry, elapsed_hold;
    logic [2:0]         active_code;
    logic [3*NUM_DIR-1:0] light_comb;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_OFF;
            elapsed_reg      <= '0;
            active_dir_reg   <= '0;
            rr_ptr_reg       <= '0;
            target_reg       <= '0;
            emgcy_active_reg <= 1'b0;
            req_reg          <= '0;
        end else begin
            state_reg        <= state_next;
            elapsed_reg      <= elapsed_next;
            active_dir_reg   <= active_dir_next;
            rr_ptr_reg       <= rr_ptr_next;
            target_reg       <= target_next;
            emgcy_active_reg <= emgcy_active_next;
            req_reg          <= req_next;
        end
    end

    // Round-robin scan over side directions starting after rr_ptr, dir 0 never a candidate.
    always_comb begin
        int cand;
        scan_dir   = '0;
        scan_found = 1'b0;
        cand       = 0;
        for (int i = 1; i < NUM_DIR; i++) begin
            cand = ((int'(rr_ptr_reg) - 1 + i) % (NUM_DIR - 1)) + 1;
            if (!scan_found && req_reg[cand[DIR_W-1:0]]) begin
                scan_found = 1'b1;
                scan_dir   = cand[DIR_W-1:0];
            end
        end
    end

    always_comb begin
        cap_dir = '0;
        for (int i = NUM_DIR - 1; i >= 0; i--) begin
            if (bus.emgcy[i]) begin
                cap_dir = DIR_W'(i);
            end
        end
    end

    assign capture      = !emgcy_active_reg && (|bus.emgcy);
    assign side_pending = |req_reg[NUM_DIR-1:1];
    assign next_dir     = (active_dir_reg == '0 && scan_found) ? scan_dir : '0;
    assign elapsed_inc  = (elapsed_reg == '1) ? elapsed_reg : elapsed_reg + 1'b1;

    // Next-state logic
    always_comb begin
        state_next        = state_reg;
        active_dir_next   = active_dir_reg;
        elapsed_hold      = 1'b0;
        target_next       = target_reg;
        emgcy_active_next = emgcy_active_reg;
        rr_ptr_next       = rr_ptr_reg;

        case (state_reg)
            ST_OFF: state_next = ST_ALLRED;
            ST_ALLRED: begin
                if (elapsed_reg == ALLRED_LAST) begin
                    if (emgcy_active_reg) begin
                        state_next      = ST_GREEN;
                        active_dir_next = target_reg;
                    end else begin
                        state_next      = ST_PREGREEN;
                        active_dir_next = next_dir;
                    end
                end
            end
            ST_PREGREEN: begin
                if (emgcy_active_reg && target_reg != active_dir_reg) begin
                    state_next = ST_ALLRED;
                end else if (elapsed_reg == PREGREEN_LAST) begin
                    state_next = ST_GREEN;
                end
            end
            ST_GREEN: begin
                if (emgcy_active_reg) begin
                    // Target green holds while its request stays up, then serves GREEN_MIN more.
                    if (target_reg != active_dir_reg) begin
                        state_next = ST_YELLOW;
                    end else if (bus.emgcy[target_reg]) begin
                        elapsed_hold = 1'b1;
                    end else if (elapsed_reg >= GMIN_LAST) begin
                        state_next = ST_YELLOW;
                    end
                end else if (capture && cap_dir == active_dir_reg) begin
                    elapsed_hold = 1'b1;
                end else if (elapsed_reg >= GMIN_LAST) begin
                    if (active_dir_reg == '0) begin
                        if (side_pending) begin
                            state_next = ST_YELLOW;
                        end
                    end else if (!bus.demand[active_dir_reg] || elapsed_reg >= GMAX_LAST) begin
                        state_next = ST_YELLOW;
                    end
                end
            end
            ST_YELLOW: begin
                if (elapsed_reg == YELLOW_LAST) begin
                    state_next = ST_ALLRED;
                end
            end
            default: state_next = ST_OFF;
        endcase

        elapsed_next = (state_next != state_reg || elapsed_hold) ? '0 : elapsed_inc;

        if (capture) begin
            emgcy_active_next = 1'b1;
            target_next       = cap_dir;
        end else if (emgcy_active_reg && state_reg == ST_GREEN &&
                     active_dir_reg == target_reg && state_next == ST_YELLOW) begin
            emgcy_active_next = 1'b0;
        end

        serve_entry = (state_next == ST_PREGREEN || state_next == ST_GREEN) &&
                      (state_next != state_reg);
        if (serve_entry && active_dir_next != '0) begin
            rr_ptr_next = active_dir_next;
        end
    end

    // A direction's request is latched unless it is already green; serving it clears it.
    assign req_next[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_DIR; gi++) begin : g_req
        assign req_next[gi] = (serve_entry && active_dir_next == DIR_W'(gi)) ? 1'b0 :
                              (req_reg[gi] | (bus.demand[gi] &&
                               !(state_reg == ST_GREEN && active_dir_reg == DIR_W'(gi))));
    end

    // Output decode from registered state only
    always_comb begin
        case (state_reg)
            ST_PREGREEN: active_code = LAMP_PREGREEN;
            ST_GREEN:    active_code = LAMP_GREEN;
            ST_YELLOW:   active_code = LAMP_YELLOW;
            default:     active_code = LAMP_RED;
        endcase
    end

    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
        assign light_comb[3*gi +: 3] =
            (state_reg == ST_OFF)               ? LAMP_OFF :
            (active_dir_reg == DIR_W'(gi))      ? active_code : LAMP_RED;
    end

    assign bus.light        = light_comb;
    assign bus.active_dir   = active_dir_reg;
    assign bus.emgcy_active = emgcy_active_reg;
endmodule

// File: tb/tb_multiway_trafficlight.sv
// Directed bench for the 4-approach controller: lamp sequences, round-robin order,
// emergency preemption/hold and mid-cycle reset.
module tb_multiway_trafficlight;
    localparam logic [2:0] C_RED = 3'd1;
    localparam logic [2:0] C_YEL = 3'd2;
    localparam logic [2:0] C_GRN = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;
    localparam logic [11:0] ALLRED = 12'h249;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    multiway_trafficlight_if #(.NUM_DIR(4)) tl_if ();

    multiway_trafficlight #(
        .NUM_DIR(4), .GREEN_MIN(4), .GREEN_MAX(8), .YELLOW_CYC(2),
        .ALLRED_CYC(1), .PREGREEN_CYC(1), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] lamp(input int dir, input logic [2:0] code);
        logic [11:0] v;
        v = ALLRED;
        v[3*dir +: 3] = code;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [11:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, 32'(tl_if.light), 32'(exp));
        end
        $display("step %-14s light=0x%03h x%0d", tag, exp, n);
    endtask

    initial begin
        reset        = 1'b1;
        tl_if.demand = 4'b0000;
        tl_if.emgcy  = 4'b0000;

        // Reset and power-up sequence
        step();
        check("s1_rst_light", 32'(tl_if.light), 32'h000);
        check("s1_rst_dir", 32'(tl_if.active_dir), 32'd0);
        check("s1_rst_emg", 32'(tl_if.emgcy_active), 32'd0);
        step();
        check("s1_rst_light2", 32'(tl_if.light), 32'h000);
        reset = 1'b0;
        run("s1_allred", ALLRED, 1);
        run("s1_pre0", lamp(0, C_PRE), 1);
        run("s1_home", lamp(0, C_GRN), 50);
        check("s1_dir", 32'(tl_if.active_dir), 32'd0);

        // Simultaneous pulses on dir1 and dir3: served 1, home, 3, home
        tl_if.demand = 4'b1010;
        run("s4_home_req", lamp(0, C_GRN), 1);
        tl_if.demand = 4'b0000;
        run("s4_yel0", lamp(0, C_YEL), 2);
        run("s4_allred_a", ALLRED, 1);
        run("s4_pre1", lamp(1, C_PRE), 1);
        run("s4_grn1", lamp(1, C_GRN), 4);
        check("s4_dir1", 32'(tl_if.active_dir), 32'd1);
        run("s4_yel1", lamp(1, C_YEL), 2);
        run("s4_allred_b", ALLRED, 1);
        run("s4_pre0", lamp(0, C_PRE), 1);
        run("s4_grn0", lamp(0, C_GRN), 4);
        run("s4_yel0b", lamp(0, C_YEL), 2);
        run("s4_allred_c", ALLRED, 1);
        run("s4_pre3", lamp(3, C_PRE), 1);
        run("s4_grn3", lamp(3, C_GRN), 4);
        check("s4_dir3", 32'(tl_if.active_dir), 32'd3);
        run("s4_yel3", lamp(3, C_YEL), 2);
        run("s4_allred_d", ALLRED, 1);
        run("s4_pre0b", lamp(0, C_PRE), 1);
        run("s4_home", lamp(0, C_GRN), 6);

        // Single-cycle demand on dir2
        tl_if.demand = 4'b0100;
        run("s2_home_req", lamp(0, C_GRN), 1);
        tl_if.demand = 4'b0000;
        run("s2_yel0", lamp(0, C_YEL), 2);
        run("s2_allred_a", ALLRED, 1);
        run("s2_pre2", lamp(2, C_PRE), 1);
        run("s2_grn2", lamp(2, C_GRN), 4);
        run("s2_yel2", lamp(2, C_YEL), 2);
        run("s2_allred_b", ALLRED, 1);
        run("s2_pre0", lamp(0, C_PRE), 1);
        run("s2_home", lamp(0, C_GRN), 6);

        // dir1 demand held 30 cycles: GREEN_MAX cap, then served again after home min green
        tl_if.demand = 4'b0010;
        run("s3_home_req", lamp(0, C_GRN), 1);
        run("s3_yel0", lamp(0, C_YEL), 2);
        run("s3_allred_a", ALLRED, 1);
        run("s3_pre1", lamp(1, C_PRE), 1);
        run("s3_grn1_max", lamp(1, C_GRN), 8);
        run("s3_yel1", lamp(1, C_YEL), 2);
        run("s3_allred_b", ALLRED, 1);
        run("s3_pre0", lamp(0, C_PRE), 1);
        run("s3_grn0_min", lamp(0, C_GRN), 4);
        run("s3_yel0b", lamp(0, C_YEL), 2);
        run("s3_allred_c", ALLRED, 1);
        run("s3_pre1b", lamp(1, C_PRE), 1);
        run("s3_grn1b", lamp(1, C_GRN), 5);
        tl_if.demand = 4'b0000;
        run("s3_yel1b", lamp(1, C_YEL), 2);
        run("s3_allred_d", ALLRED, 1);
        run("s3_pre0b", lamp(0, C_PRE), 1);
        run("s3_home", lamp(0, C_GRN), 2);

        // Emergency on dir3 while home green at elapsed=1
        check("s5_emg_idle", 32'(tl_if.emgcy_active), 32'd0);
        tl_if.emgcy = 4'b1000;
        run("s5_capture", lamp(0, C_GRN), 1);
        check("s5_emg_set", 32'(tl_if.emgcy_active), 32'd1);
        run("s5_yel0", lamp(0, C_YEL), 2);
        tl_if.emgcy = 4'b0000;
        run("s5_allred", ALLRED, 1);
        run("s5_grn3", lamp(3, C_GRN), 4);
        check("s5_dir3", 32'(tl_if.active_dir), 32'd3);
        check("s5_emg_hold", 32'(tl_if.emgcy_active), 32'd1);
        run("s5_yel3", lamp(3, C_YEL), 1);
        check("s5_emg_clr", 32'(tl_if.emgcy_active), 32'd0);
        run("s5_yel3b", lamp(3, C_YEL), 1);
        run("s5_allred_b", ALLRED, 1);
        run("s5_pre0", lamp(0, C_PRE), 1);
        run("s5_home", lamp(0, C_GRN), 6);

        // Emergency on the direction already green: hold, then GREEN_MIN after release
        tl_if.emgcy = 4'b0001;
        run("s5b_hold", lamp(0, C_GRN), 3);
        tl_if.emgcy = 4'b0000;
        run("s5b_min", lamp(0, C_GRN), 3);
        check("s5b_emg_on", 32'(tl_if.emgcy_active), 32'd1);
        run("s5b_yel0", lamp(0, C_YEL), 2);
        check("s5b_emg_off", 32'(tl_if.emgcy_active), 32'd0);
        run("s5b_allred", ALLRED, 1);
        run("s5b_pre0", lamp(0, C_PRE), 1);
        run("s5b_home", lamp(0, C_GRN), 5);

        // Reset during dir2 yellow with dir1 pending
        tl_if.demand = 4'b0100;
        run("s6_home_req", lamp(0, C_GRN), 1);
        tl_if.demand = 4'b0000;
        run("s6_yel0", lamp(0, C_YEL), 2);
        run("s6_allred", ALLRED, 1);
        run("s6_pre2", lamp(2, C_PRE), 1);
        run("s6_grn2a", lamp(2, C_GRN), 1);
        tl_if.demand = 4'b0010;
        run("s6_grn2b", lamp(2, C_GRN), 1);
        tl_if.demand = 4'b0000;
        run("s6_grn2c", lamp(2, C_GRN), 2);
        run("s6_yel2", lamp(2, C_YEL), 1);
        reset = 1'b1;
        step();
        check("s6_rst_light", 32'(tl_if.light), 32'h000);
        check("s6_rst_dir", 32'(tl_if.active_dir), 32'd0);
        check("s6_rst_emg", 32'(tl_if.emgcy_active), 32'd0);
        reset = 1'b0;
        run("s6_allred_b", ALLRED, 1);
        run("s6_pre0", lamp(0, C_PRE), 1);
        run("s6_home_stay", lamp(0, C_GRN), 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
